kamacore_writeback_arbiter: RTL and testbench

Shares the register file's single write port between several writeback sources, such as the ALU, load unit and CSR unit. Each source presents a valid/ready request carrying a destination address and data. A round-robin arbiter grants at most one request per cycle. The granted write is captured in a one-entry output stage that drives the register file's `destination_we` / `destination_a` / `destination_data` inputs.

---
 rtl/kamacore_pkg.sv | 14 +
 rtl/kamacore_rr_arbiter.sv | 46 ++++
 rtl/kamacore_writeback_arbiter.sv | 89 ++++++++
 tb/tb_kamacore_writeback_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/kamacore_pkg.sv
// Shared core widths and the writeback request payload type.
package kamacore_pkg;

  localparam int CPU_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] a;
    logic [CPU_WIDTH-1:0]      data;
  } wb_req_t;

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;

endpackage

// File: rtl/kamacore_rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant searched from ptr, ptr moves past the winner.
module kamacore_rr_arbiter #(
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int off = 0; off < N; off++) begin
      k = int'(ptr_q) + off;
      if (k >= N) k = k - N;
      if (!found && req[k]) begin
        found   = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = IW'(k);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found)
      ptr_d = (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + IW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/kamacore_writeback_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources through a
// round-robin grant and a one-entry output stage that drains every cycle.
module kamacore_writeback_arbiter
  import kamacore_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ-1:0]                       req_valid,
  input  logic [NUM_REQ-1:0][REG_ADDR_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ-1:0][CPU_WIDTH-1:0]        req_data,
  output logic [NUM_REQ-1:0]                       req_ready,
  output logic                                     destination_we,
  output logic [REG_ADDR_WIDTH-1:0]                destination_a,
  output logic [CPU_WIDTH-1:0]                     destination_data,
  output logic [$clog2(NUM_REQ)-1:0]               grant_id
);

  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] gnt;
  logic [GW-1:0]      gnt_idx;
  logic               grant;
  wb_req_t            req [NUM_REQ];
  wb_req_t            sel;

  logic                      we_q, we_d;
  logic [REG_ADDR_WIDTH-1:0] a_q, a_d;
  logic [CPU_WIDTH-1:0]      data_q, data_d;
  logic [GW-1:0]             gid_q, gid_d;

  // The output stage never stalls, so the pointer may advance on every grant.
  kamacore_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (1'b1),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
    assign req[i] = '{a: req_a[i], data: req_data[i]};
  end

  assign grant     = |gnt;
  assign req_ready = rst ? gnt : '0;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) sel = req[i];
  end

  // x0 writes are consumed but never reach the register file.
  always_comb begin
    we_d   = 1'b0;
    a_d    = a_q;
    data_d = data_q;
    gid_d  = gid_q;
    if (grant) begin
      we_d   = (sel.a != ZERO_REG);
      a_d    = sel.a;
      data_d = sel.data;
      gid_d  = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q   <= 1'b0;
      a_q    <= '0;
      data_q <= '0;
      gid_q  <= '0;
    end else begin
      we_q   <= we_d;
      a_q    <= a_d;
      data_q <= data_d;
      gid_q  <= gid_d;
    end
  end

  assign destination_we   = we_q;
  assign destination_a    = a_q;
  assign destination_data = data_q;
  assign grant_id         = gid_q;

endmodule

// File: tb/tb_kamacore_writeback_arbiter.sv
// Bench for kamacore_writeback_arbiter: reset sequence, then a vector table with
// expected port writes queued at drive time and popped one cycle later.
module tb_kamacore_writeback_arbiter;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [2:0]      req_valid = '0;
  logic [2:0][4:0] req_a = '0;
  logic [2:0][31:0] req_data = '0;
  logic [2:0]      req_ready;
  logic            destination_we;
  logic [4:0]      destination_a;
  logic [31:0]     destination_data;
  logic [1:0]      grant_id;

  kamacore_writeback_arbiter #(.NUM_REQ(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_a            (req_a),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .destination_we   (destination_we),
    .destination_a    (destination_a),
    .destination_data (destination_data),
    .grant_id         (grant_id)
  );

  always #5 clk = ~clk;

  // Register-file model fed by the write port.
  logic [31:0] rf [32] = '{default: 32'h0};
  always @(posedge clk)
    if (destination_we) rf[destination_a] <= destination_data;

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic [1:0]  gid;
  } out_t;

  typedef struct {
    logic [2:0]       v;
    logic [2:0][4:0]  a;
    logic [2:0][31:0] d;
    logic [2:0]       rdy;
    out_t             o;
  } vec_t;

  int   n_vec  = 0;
  int   n_miss = 0;
  out_t sb [$];
  vec_t tbl [14];

  function automatic vec_t mk(logic [2:0] v, logic [4:0] a2, logic [4:0] a1, logic [4:0] a0,
                              logic [31:0] d2, logic [31:0] d1, logic [31:0] d0,
                              logic [2:0] rdy, logic we, logic [4:0] oa, logic [31:0] od,
                              logic [1:0] gid);
    vec_t r;
    r.v = v; r.a = {a2, a1, a0}; r.d = {d2, d1, d0}; r.rdy = rdy;
    r.o = '{we: we, a: oa, d: od, gid: gid};
    return r;
  endfunction

  task automatic check_out(input string name, input out_t e);
    n_vec++;
    if (destination_we !== e.we || destination_a !== e.a ||
        destination_data !== e.d || grant_id !== e.gid) begin
      n_miss++;
      $display("FAIL %s: got we=%0b a=%0d data=%h gid=%0d, want we=%0b a=%0d data=%h gid=%0d",
               name, destination_we, destination_a, destination_data, grant_id,
               e.we, e.a, e.d, e.gid);
    end
  endtask

  task automatic check_rdy(input string name, input logic [2:0] e);
    n_vec++;
    if (req_ready !== e) begin
      n_miss++;
      $display("FAIL %s: got req_ready=%b, want %b", name, req_ready, e);
    end
  endtask

  task automatic check_rf(input string name, input int idx, input logic [31:0] e);
    n_vec++;
    if (rf[idx] !== e) begin
      n_miss++;
      $display("FAIL %s: got x%0d=%h, want %h", name, idx, rf[idx], e);
    end
  endtask

  initial begin
    // ptr starts the table at 1 (left there by the reset sequence).
    tbl[0]  = mk(3'b010, 0, 5, 0,  0, 32'hDEADBEEF, 0,  3'b010, 1, 5, 32'hDEADBEEF, 1);
    tbl[1]  = mk(3'b011, 0, 6, 4,  0, 66, 44,           3'b001, 1, 4, 44, 0);
    tbl[2]  = mk(3'b010, 0, 6, 4,  0, 66, 44,           3'b010, 1, 6, 66, 1);
    tbl[3]  = mk(3'b000, 0, 0, 0,  0, 0, 0,             3'b000, 0, 6, 66, 1);
    tbl[4]  = mk(3'b101, 0, 0, 9,  32'h1234, 0, 99,     3'b100, 0, 0, 32'h1234, 2);
    tbl[5]  = mk(3'b111, 11, 10, 9, 222, 111, 99,       3'b001, 1, 9, 99, 0);
    tbl[6]  = mk(3'b111, 11, 10, 9, 222, 111, 99,       3'b010, 1, 10, 111, 1);
    tbl[7]  = mk(3'b111, 11, 10, 9, 222, 111, 99,       3'b100, 1, 11, 222, 2);
    tbl[8]  = mk(3'b111, 11, 10, 9, 222, 111, 99,       3'b001, 1, 9, 99, 0);
    tbl[9]  = mk(3'b111, 11, 10, 9, 222, 111, 99,       3'b010, 1, 10, 111, 1);
    tbl[10] = mk(3'b111, 11, 10, 9, 222, 111, 99,       3'b100, 1, 11, 222, 2);
    tbl[11] = mk(3'b011, 0, 7, 7,  0, 22, 11,           3'b001, 1, 7, 11, 0);
    tbl[12] = mk(3'b010, 0, 7, 7,  0, 22, 11,           3'b010, 1, 7, 22, 1);
    tbl[13] = mk(3'b000, 0, 0, 0,  0, 0, 0,             3'b000, 0, 7, 22, 1);

    // Reset state and first grant after release.
    repeat (2) @(negedge clk);
    check_out("reset_state", '{we: 0, a: 0, d: 0, gid: 0});
    rst = 1'b1;
    req_valid = 3'b111;
    req_a = {5'd12, 5'd8, 5'd3};
    req_data = {32'hCCCC, 32'hBBBB, 32'hAAAA};
    #1 check_rdy("first_grant_rdy", 3'b001);
    @(negedge clk);
    check_out("first_grant_out", '{we: 1, a: 3, d: 32'hAAAA, gid: 0});
    check_rdy("second_grant_rdy", 3'b010);
    @(negedge clk);
    check_out("second_grant_out", '{we: 1, a: 8, d: 32'hBBBB, gid: 1});

    // Mid-cycle asynchronous reset with all requesters valid.
    #2 rst = 1'b0;
    #1 check_out("async_reset_out", '{we: 0, a: 0, d: 0, gid: 0});
    check_rdy("async_reset_rdy", 3'b000);
    @(negedge clk);
    check_out("reset_held_out", '{we: 0, a: 0, d: 0, gid: 0});
    rst = 1'b1;
    #1 check_rdy("ptr_cleared_rdy", 3'b001);
    @(negedge clk);
    check_out("post_reset_out", '{we: 1, a: 3, d: 32'hAAAA, gid: 0});
    req_valid = 3'b000;
    @(negedge clk);
    check_out("post_reset_idle", '{we: 0, a: 3, d: 32'hAAAA, gid: 0});

    foreach (tbl[i]) begin
      if (sb.size() != 0) check_out($sformatf("row%0d_out", i - 1), sb.pop_front());
      req_valid = tbl[i].v;
      req_a     = tbl[i].a;
      req_data  = tbl[i].d;
      #1 check_rdy($sformatf("row%0d_rdy", i), tbl[i].rdy);
      sb.push_back(tbl[i].o);
      @(negedge clk);
    end
    while (sb.size() != 0) check_out("drain_out", sb.pop_front());

    check_rf("rf_x7_last_wins", 7, 32'd22);
    check_rf("rf_x0_untouched", 0, 32'd0);
    check_rf("rf_x5", 5, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
